// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM/WB hazard inputs and the
// stall/flush/redirect/forwarding controls returned to the pipeline.
interface riscv_hazard_ctrl_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [RA_W-1:0] ex_rd;
    logic [RA_W-1:0] mem_rd;
    logic [RA_W-1:0] wb_rd;
    logic            ex_we;
    logic            mem_we;
    logic            wb_we;
    logic            ex_memread;
    logic            imem_busywait;
    logic            dmem_busywait;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    logic            pc_stall;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_redirect_target;
    logic            if_id_stall;
    logic            if_id_flush;
    logic            id_ex_stall;
    logic            id_ex_flush;
    logic            ex_mem_stall;
    logic            mem_wb_stall;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;

    // Pipeline side: supplies hazard info, consumes controls.
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we,
        output ex_memread, imem_busywait, dmem_busywait,
        output branch_taken, branch_target,
        input  pc_stall, pc_redirect, pc_redirect_target,
        input  if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_stall, mem_wb_stall, fwd_a_sel, fwd_b_sel
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we,
        input  ex_memread, imem_busywait, dmem_busywait,
        input  branch_taken, branch_target,
        output pc_stall, pc_redirect, pc_redirect_target,
        output if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_stall, mem_wb_stall, fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Central stall/flush/redirect/forwarding controller, 5-stage RV32.
// Optional macro FWD_EN: enables EX/MEM and MEM/WB operand forwarding.
module riscv_hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int LU_BUBBLES = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    riscv_hazard_ctrl_if.slave    hz
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_STALL   = 2'd1,
        REDIR_PEND = 2'd2
    } state_e;

    localparam logic [2:0] LU_INIT  = 3'(LU_BUBBLES - 1);
    localparam bit         LU_MULTI = (LU_BUBBLES > 1);

`ifdef FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [2:0]      lu_cnt_q, lu_cnt_d;
    logic [XLEN-1:0] target_q, target_d;

    logic a_ex, a_mem, a_wb;
    logic b_ex, b_mem, b_wb;
    logic hazard;
    logic [1:0] fwd_a, fwd_b;

    logic            pc_stall, pc_redirect;
    logic [XLEN-1:0] redir_tgt;
    logic            if_id_stall, if_id_flush;
    logic            id_ex_stall, id_ex_flush;
    logic            ex_mem_stall, mem_wb_stall;

    // A source matches a stage only if it is read, written, and not x0.
    function automatic logic hit(
        input logic            used,
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] rd,
        input logic            we
    );
        return used && we && (rd != '0) && (rs == rd);
    endfunction

    // Per-source/per-stage RAW match terms.
    always_comb begin
        a_ex  = hit(hz.id_rs1_used, hz.id_rs1, hz.ex_rd,  hz.ex_we);
        a_mem = hit(hz.id_rs1_used, hz.id_rs1, hz.mem_rd, hz.mem_we);
        a_wb  = hit(hz.id_rs1_used, hz.id_rs1, hz.wb_rd,  hz.wb_we);
        b_ex  = hit(hz.id_rs2_used, hz.id_rs2, hz.ex_rd,  hz.ex_we);
        b_mem = hit(hz.id_rs2_used, hz.id_rs2, hz.mem_rd, hz.mem_we);
        b_wb  = hit(hz.id_rs2_used, hz.id_rs2, hz.wb_rd,  hz.wb_we);
    end

`ifdef FWD_EN
    // Forward youngest producer first; only a load in EX must interlock.
    always_comb begin
        fwd_a  = a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
        fwd_b  = b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
        hazard = hz.ex_memread && (a_ex || b_ex);
    end
`else
    // No bypass and no write-through: any in-flight producer interlocks.
    always_comb begin
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
        hazard = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
    end
`endif

    // Next-state and control outputs; dmem wait freezes everything.
    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        target_d     = target_q;
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        redir_tgt    = '0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if (!RESET) begin
            state_d  = RUN;
            lu_cnt_d = '0;
            target_d = '0;
        end else if (hz.dmem_busywait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (hz.branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            lu_cnt_d    = '0;
            if (hz.imem_busywait) begin
                pc_stall = 1'b1;
                target_d = hz.branch_target;
                state_d  = REDIR_PEND;
            end else begin
                pc_redirect = 1'b1;
                redir_tgt   = hz.branch_target;
                state_d     = RUN;
            end
        end else begin
            unique case (state_q)
                REDIR_PEND: begin
                    if (hz.imem_busywait) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_redirect = 1'b1;
                        redir_tgt   = target_q;
                        state_d     = RUN;
                    end
                end
                LU_STALL: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    lu_cnt_d    = lu_cnt_q - 3'd1;
                    if (lu_cnt_q <= 3'd1) begin
                        state_d  = RUN;
                        lu_cnt_d = '0;
                    end
                end
                default: begin
                    if (hazard) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FWD_ON && LU_MULTI) begin
                            lu_cnt_d = LU_INIT;
                            state_d  = LU_STALL;
                        end
                    end else if (hz.imem_busywait) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, bubble counter and pending redirect target.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            target_q <= target_d;
        end
    end

    // Drive the bundle; every control reads 0 while reset is held.
    always_comb begin
        hz.pc_stall           = pc_stall;
        hz.pc_redirect        = pc_redirect;
        hz.pc_redirect_target = redir_tgt;
        hz.if_id_stall        = if_id_stall;
        hz.if_id_flush        = if_id_flush;
        hz.id_ex_stall        = id_ex_stall;
        hz.id_ex_flush        = id_ex_flush;
        hz.ex_mem_stall       = ex_mem_stall;
        hz.mem_wb_stall       = mem_wb_stall;
        hz.fwd_a_sel          = RESET ? fwd_a : 2'b00;
        hz.fwd_b_sel          = RESET ? fwd_b : 2'b00;
    end

endmodule
